// File: rtl/ifft_radix2.sv
// rtl/ifft_radix2.sv - frame-based in-place radix-2 inverse FFT, one butterfly per clock
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    frame start pulse, honoured only when idle
//   din_real/imag/valid      frequency-domain bins in natural order
//   din_ready                high while bins are being loaded
//   dout_real/imag/valid     time-domain samples in natural order (zero when not valid)
//   dout_ready               downstream accept
//   dout_last                marks sample N-1
//   busy                     frame in progress
//   done                     one-cycle pulse after the last output handshake
module ifft_radix2 #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TWID_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din_real,
    input  logic [DATA_WIDTH-1:0] din_imag,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout_real,
    output logic [DATA_WIDTH-1:0] dout_imag,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  busy,
    output logic                  done
);
    localparam int  LOGN = $clog2(N);
    localparam int  DW   = DATA_WIDTH;
    localparam int  TW   = TWID_WIDTH;
    localparam int  DW1  = DW + 1;
    localparam int  DW2  = DW + 2;
    localparam int  PW   = DW + TW + 1;
    localparam int  SW   = 3;
    localparam int  BW   = LOGN - 1;
    localparam real PI   = 3.14159265358979323846;

    localparam logic signed [DW2-1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW2-1:0] SMIN = {3'b111, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

    // Round to nearest Q1.(TW-1); +1.0 clamps to the largest positive code.
    function automatic logic signed [TW-1:0] to_fix(input real v);
        real s;
        s = v * (2.0 ** (TW - 1));
        if (s >= (2.0 ** (TW - 1)) - 0.5) return {1'b0, {(TW-1){1'b1}}};
        if (s >= 0.0) return TW'($rtoi(s + 0.5));
        return TW'($rtoi(s - 0.5));
    endfunction

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
        return r;
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [DW2-1:0] v);
        if (v > SMAX) return SMAX[DW-1:0];
        if (v < SMIN) return SMIN[DW-1:0];
        return v[DW-1:0];
    endfunction

    // Twiddle ROM: entry r = exp(+j*2*pi*r/N), the conjugate of the forward FFT twiddles.
    logic signed [TW-1:0] rom_re [N/2];
    logic signed [TW-1:0] rom_im [N/2];
    for (genvar r = 0; r < N/2; r++) begin : g_rom
        localparam real ANG = 2.0 * PI * r / N;
        localparam logic signed [TW-1:0] W_RE = to_fix($cos(ANG));
        localparam logic signed [TW-1:0] W_IM = to_fix($sin(ANG));
        assign rom_re[r] = W_RE;
        assign rom_im[r] = W_IM;
    end

    state_t               state_q, state_d;
    logic [LOGN-1:0]      in_cnt_q, in_cnt_d;
    logic [BW-1:0]        bf_q, bf_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic [LOGN-1:0]      out_idx_q, out_idx_d;
    logic                 done_q, done_d;
    logic signed [DW-1:0] buf_re_q [N];
    logic signed [DW-1:0] buf_im_q [N];
    logic signed [DW-1:0] buf_re_d [N];
    logic signed [DW-1:0] buf_im_d [N];

    // Butterfly addressing: bf counts butterflies within a stage, group-major.
    // jmask keeps the low 'stage' bits (the j index); the rest selects the group.
    // At the top stage the shift wraps to zero, and zero minus one is the full mask.
    logic [BW-1:0]        jmask, j_idx, tw_idx;
    logic [LOGN-1:0]      a_addr, b_addr;
    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [TW-1:0] wr, wi;
    logic signed [PW-1:0] prod_r, prod_i;
    logic signed [DW1-1:0] t_r, t_i;
    logic signed [DW2-1:0] sa_r, sa_i, sd_r, sd_i;

    always_comb begin
        jmask  = (BW'(1) << stage_q) - BW'(1);
        j_idx  = bf_q & jmask;
        a_addr = {bf_q & ~jmask, 1'b0} | {1'b0, j_idx};
        b_addr = a_addr | (LOGN'(1) << stage_q);
        tw_idx = j_idx << (SW'(LOGN - 1) - stage_q);
        ar     = buf_re_q[a_addr];
        ai     = buf_im_q[a_addr];
        br     = buf_re_q[b_addr];
        bi     = buf_im_q[b_addr];
        wr     = rom_re[tw_idx];
        wi     = rom_im[tw_idx];
        prod_r = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi);
        prod_i = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr);
        if (j_idx == '0) begin
            // Unity twiddle: skip the multiplier so B passes through exactly.
            t_r = DW1'(br);
            t_i = DW1'(bi);
        end else begin
            t_r = DW1'(prod_r >>> (TW - 1));
            t_i = DW1'(prod_i >>> (TW - 1));
        end
        sa_r = DW2'(ar) + DW2'(t_r);
        sa_i = DW2'(ai) + DW2'(t_i);
        sd_r = DW2'(ar) - DW2'(t_r);
        sd_i = DW2'(ai) - DW2'(t_i);
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        bf_d      = bf_q;
        stage_d   = stage_q;
        out_idx_d = out_idx_q;
        done_d    = 1'b0;
        buf_re_d  = buf_re_q;
        buf_im_d  = buf_im_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    in_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (din_valid) begin
                    buf_re_d[bitrev(in_cnt_q)] = din_real;
                    buf_im_d[bitrev(in_cnt_q)] = din_imag;
                    in_cnt_d = in_cnt_q + LOGN'(1);
                    if (in_cnt_q == LOGN'(N - 1)) begin
                        state_d = S_COMPUTE;
                        bf_d    = '0;
                        stage_d = '0;
                    end
                end
            end
            S_COMPUTE: begin
                buf_re_d[a_addr] = sat(sa_r >>> 1);
                buf_im_d[a_addr] = sat(sa_i >>> 1);
                buf_re_d[b_addr] = sat(sd_r >>> 1);
                buf_im_d[b_addr] = sat(sd_i >>> 1);
                if (bf_q == BW'(N / 2 - 1)) begin
                    bf_d = '0;
                    if (stage_q == SW'(LOGN - 1)) begin
                        state_d   = S_OUTPUT;
                        out_idx_d = '0;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    bf_d = bf_q + BW'(1);
                end
            end
            S_OUTPUT: begin
                if (dout_ready) begin
                    if (out_idx_q == LOGN'(N - 1)) begin
                        state_d   = S_IDLE;
                        out_idx_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        out_idx_d = out_idx_q + LOGN'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= '0;
            bf_q      <= '0;
            stage_q   <= '0;
            out_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            bf_q      <= bf_d;
            stage_q   <= stage_d;
            out_idx_q <= out_idx_d;
            done_q    <= done_d;
        end
    end

    // Sample buffer carries no reset; every frame overwrites all N entries on load.
    always_ff @(posedge clk) begin
        buf_re_q <= buf_re_d;
        buf_im_q <= buf_im_d;
    end

    assign din_ready  = (state_q == S_LOAD);
    assign dout_valid = (state_q == S_OUTPUT);
    assign dout_last  = (state_q == S_OUTPUT) && (out_idx_q == LOGN'(N - 1));
    assign dout_real  = dout_valid ? buf_re_q[out_idx_q] : '0;
    assign dout_imag  = dout_valid ? buf_im_q[out_idx_q] : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
endmodule

// File: tb/tb_ifft_radix2.sv
// tb/tb_ifft_radix2.sv - directed scoreboard bench for ifft_radix2
module tb_ifft_radix2;
    localparam int  N  = 8;
    localparam int  DW = 16;
    localparam int  TW = 16;
    localparam real PI = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] din_real = '0;
    logic [DW-1:0] din_imag = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [DW-1:0] dout_real;
    logic [DW-1:0] dout_imag;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          dout_last;
    logic          busy;
    logic          done;

    ifft_radix2 #(.N(N), .DATA_WIDTH(DW), .TWID_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .din_real(din_real), .din_imag(din_imag), .din_valid(din_valid), .din_ready(din_ready),
        .dout_real(dout_real), .dout_imag(dout_imag), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int re;
        int im;
        int tol;
    } exp_t;
    exp_t sb[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic chk_tol(input string tag, input int obs, input int expv, input int tol);
        n_total++;
        assert ((obs - expv) <= tol && (expv - obs) <= tol) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
    endtask

    // Reference model: x[n] = (1/N) * sum_k X[k] * exp(+j*2*pi*k*n/N), rounded.
    task automatic push_frame(input int xr[N], input int xi[N], input int tol);
        for (int n = 0; n < N; n++) begin
            real sr, si, ang;
            exp_t e;
            sr = 0.0;
            si = 0.0;
            for (int k = 0; k < N; k++) begin
                ang = 2.0 * PI * k * n / N;
                sr = sr + xr[k] * $cos(ang) - xi[k] * $sin(ang);
                si = si + xr[k] * $sin(ang) + xi[k] * $cos(ang);
            end
            sr = sr / N;
            si = si / N;
            e.re  = (sr >= 0.0) ? $rtoi(sr + 0.5) : $rtoi(sr - 0.5);
            e.im  = (si >= 0.0) ? $rtoi(si + 0.5) : $rtoi(si - 0.5);
            e.tol = tol;
            sb.push_back(e);
        end
    endtask

    task automatic run_frame(input int xr[N], input int xi[N], input int tol, input int gap,
                             input bit alt_ready, input bit disturb, input int abort_at);
        int accepted, t, guard, last_acc, got;
        bit rdy;
        exp_t e;
        push_frame(xr, xi, tol);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("din_ready_in_load", int'(din_ready), 1);
        accepted = 0;
        t = 0;
        guard = 0;
        last_acc = 0;
        while (accepted < N && guard < 200) begin
            din_valid = ((t % gap) == 0);
            din_real  = DW'(xr[accepted]);
            din_imag  = DW'(xi[accepted]);
            if (din_valid && din_ready) begin
                last_acc = cyc;
                accepted++;
            end
            t++;
            guard++;
            @(negedge clk);
        end
        din_valid = 1'b0;
        chk("bins_accepted", accepted, N);
        chk("din_ready_after_load", int'(din_ready), 0);

        if (abort_at >= 0) begin
            repeat (abort_at) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("abort_busy", int'(busy), 0);
            chk("abort_dout_valid", int'(dout_valid), 0);
            chk("abort_din_ready", int'(din_ready), 0);
            @(negedge clk);
            rst_n = 1'b1;
            sb.delete();
            return;
        end

        guard = 0;
        while (!dout_valid && guard < 100) begin
            if (disturb) begin
                start     = guard[0];
                din_valid = ~guard[0];
                din_real  = DW'(12345);
                din_imag  = DW'(-321);
                chk("busy_in_compute", int'(busy), 1);
            end
            guard++;
            @(negedge clk);
        end
        start     = 1'b0;
        din_valid = 1'b0;
        chk("first_valid_latency", cyc - last_acc, 13);

        got = 0;
        guard = 0;
        rdy = 1'b1;
        while (got < N && guard < 200 && sb.size() > 0) begin
            dout_ready = alt_ready ? rdy : 1'b1;
            if (disturb) begin
                start = guard[0];
                chk("busy_in_output", int'(busy), 1);
            end
            chk("dout_valid", int'(dout_valid), 1);
            e = sb[0];
            chk_tol($sformatf("dout_real[%0d]", got), int'($signed(dout_real)), e.re, e.tol);
            chk_tol($sformatf("dout_imag[%0d]", got), int'($signed(dout_imag)), e.im, e.tol);
            chk($sformatf("dout_last[%0d]", got), int'(dout_last), int'(got == N - 1));
            if (dout_ready && dout_valid) begin
                void'(sb.pop_front());
                got++;
            end
            rdy = ~rdy;
            guard++;
            @(negedge clk);
        end
        dout_ready = 1'b0;
        start      = 1'b0;
        chk("transfers", got, N);
        chk("done_pulse", int'(done), 1);
        chk("busy_after_frame", int'(busy), 0);
        chk("dout_valid_after_frame", int'(dout_valid), 0);
        chk("dout_real_idle_zero", int'(dout_real), 0);
        @(negedge clk);
        chk("done_single_cycle", int'(done), 0);
    endtask

    initial begin
        int xr[N];
        int xi[N];

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_din_ready", int'(din_ready), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_dout_last", int'(dout_last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dout_real", int'(dout_real), 0);
        chk("rst_dout_imag", int'(dout_imag), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // din_valid while idle must be ignored
        din_valid = 1'b1;
        @(negedge clk);
        chk("idle_ignores_din", int'(busy), 0);
        din_valid = 1'b0;

        // DC impulse: all outputs exactly 1000+0j
        for (int k = 0; k < N; k++) begin xr[k] = 0; xi[k] = 0; end
        xr[0] = 8000;
        run_frame(xr, xi, 0, 1, 1'b0, 1'b0, -1);

        // single tone on bin 1
        for (int k = 0; k < N; k++) begin xr[k] = 0; xi[k] = 0; end
        xr[1] = 8000;
        run_frame(xr, xi, 2, 1, 1'b0, 1'b0, -1);

        // full-scale in every bin
        for (int k = 0; k < N; k++) begin xr[k] = 32767; xi[k] = 0; end
        run_frame(xr, xi, 1, 1, 1'b0, 1'b0, -1);

        // gapped input plus alternating backpressure
        for (int k = 0; k < N; k++) begin xr[k] = 0; xi[k] = 0; end
        xr[1] = 8000;
        run_frame(xr, xi, 2, 3, 1'b1, 1'b0, -1);

        // stray start/din_valid during compute and output
        for (int k = 0; k < N; k++) begin xr[k] = 0; xi[k] = 0; end
        xr[0] = 8000;
        run_frame(xr, xi, 0, 1, 1'b0, 1'b1, -1);

        // reset mid-compute, then a clean impulse frame
        run_frame(xr, xi, 0, 1, 1'b0, 1'b0, 4);
        run_frame(xr, xi, 0, 1, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ifft_radix2.md
Name: ifft_radix2

Overview:
Frame-based radix-2 inverse FFT. It is the return path for the forward FFT in the DSP subsystem: it takes N frequency-domain bins and produces N time-domain samples in natural order. It runs one butterfly per clock through a single in-place buffer, with 1/2 scaling per stage, so the overall scale is 1/N. Ready/valid streaming is used on both sides, and the output honours backpressure.

Parameters:
N, 8, transform length; power of two, 4..64
DATA_WIDTH, 16, signed sample width, real and imag
TWID_WIDTH, 16, signed twiddle width, Q1.(TWID_WIDTH-1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  frame start pulse; honoured only in IDLE
din_real  in  DATA_WIDTH  bin real part, signed
din_imag  in  DATA_WIDTH  bin imag part, signed
din_valid  in  1  input bin valid
din_ready  out  1  high only in LOAD
dout_real  out  DATA_WIDTH  time sample real part; 0 when dout_valid=0
dout_imag  out  DATA_WIDTH  time sample imag part; 0 when dout_valid=0
dout_valid  out  1  high only in OUTPUT
dout_ready  in  1  downstream accept
dout_last  out  1  high with sample N-1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset: state=IDLE. All counters are 0. din_ready, dout_valid, dout_last, busy and done are 0. dout_real and dout_imag are 0. Buffer contents are not reset.
- FSM: IDLE -> LOAD -> COMPUTE -> OUTPUT -> IDLE.
- IDLE:
  - start=1 -> LOAD next cycle, in_cnt=0.
  - din_valid is ignored.
- LOAD:
  - din_ready=1.
  - Each din_valid&din_ready writes bin in_cnt to buffer address bitrev(in_cnt), then in_cnt++.
  - Gaps in din_valid are allowed.
  - The Nth accept moves to COMPUTE next cycle.
- COMPUTE:
  - Exactly C=(N/2)*log2(N) cycles.
  - Stage s=0..log2N-1 with m=2^(s+1).
  - Butterflies are ordered by group k, then j=0..m/2-1, with A=buf[k+j] and B=buf[k+j+m/2].
  - Twiddle W=exp(+j*2*pi*j/m), the conjugate of the forward transform. Values come from a constant ROM with N/2 entries, built at elaboration.
  - j=0 bypasses the multiplier: t=B exactly.
  - Otherwise t=(B*W)>>>(TWID_WIDTH-1): complex multiply, arithmetic shift, truncation.
  - A'=(A+t)>>>1 and B'=(A-t)>>>1. Sums are formed at DATA_WIDTH+2 bits, then saturated to DATA_WIDTH.
  - Both results are written back in the same cycle. The next butterfly reads the updated values.
- OUTPUT:
  - dout_valid=1 and dout = buf[out_idx], with out_idx running 0..N-1.
  - out_idx advances only on dout_valid&dout_ready. Data is held stable while dout_ready=0.
  - dout_last=1 when out_idx=N-1.
  - The handshake on N-1 moves to IDLE. done=1 for that next cycle only.
- Latency: if the last input is accepted at cycle L, then COMPUTE occupies L+1..L+C and dout_valid first rises at L+C+1. N=8 gives C=12.
- start outside IDLE is ignored, and so is din_valid outside LOAD.
- start in the same cycle that done is high is accepted, because the state is IDLE.
- Reset asserted mid-frame clears everything immediately, asynchronously. The partial frame is discarded. The next frame after release is computed correctly.
- Exactness: bins that are multiples of N/2 ... the impulse and DC cases below are bit-exact. Other bins are within ±2 LSB of ideal IDFT/N.

Test Plan:
- N=8; bins X[0]=8000+0j, others 0 -> all 8 outputs exactly 1000+0j; dout_last on the 8th; done pulses once the following cycle.
- X[1]=8000+0j, others 0 -> x[n]≈1000*exp(j*2*pi*n/8) within ±2 LSB; e.g. x[0]=(1000,0), x[2]=(0,1000), x[4]=(-1000,0), x[1]≈(707,707).
- All 8 bins = 32767+0j -> x[0]=32767 (±1), x[1..7]=0 (±1); no wrap, saturation holds.
- Input din_valid pattern 1,0,0,1,... plus dout_ready alternating 1/0 -> 8 bins accepted, first dout_valid exactly 13 cycles after last accept, each output held while dout_ready=0, exactly 8 transfers.
- start pulsed during COMPUTE and OUTPUT, din_valid pulsed during COMPUTE -> no effect: buffer unchanged, single done, busy stays 1 until frame end.
- rst_n low mid-COMPUTE -> busy, dout_valid and din_ready drop at once; after release, start plus impulse frame -> all outputs 1000+0j.
